// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
// Module   : uart_recv
// Summary  : 8N1 UART receiver timed by an external oversample tick (pulse).
// Revision : 1.0
// ============================================================================
module uart_recv #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  input  logic       signal,
  output logic [7:0] character,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic             sync1_q;
  logic             rx_s_q;
  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       character_q, character_d;
  logic             valid_q,     valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    character_d = character_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pulse && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line half a bit into the start bit to reject glitches.
      S_START: begin
        if (pulse) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            state_d   = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_DATA: begin
        if (pulse) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d              = '0;
            shift_d[bit_idx_q] = rx_s_q;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_STOP: begin
        if (pulse) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s_q) begin
              character_d = shift_q;
              valid_d     = 1'b1;
              state_d     = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      // A broken frame leaves the line low; wait for it to recover first.
      S_WAIT_IDLE: begin
        if (pulse && rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      character_q <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= signal;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      character_q <= character_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign character = character_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// Bench for uart_recv: OVERSAMPLE=16 directed frames plus an OVERSAMPLE=4
// random stream, checked by scoreboard queues popped on valid strobes.
module tb_uart_recv;

  logic       clk = 1'b0;
  logic       rst16 = 1'b1, pulse16 = 1'b0, sig16 = 1'b1;
  logic       rst4 = 1'b1, sig4 = 1'b1;
  logic       pulse4 = 1'b1;
  logic [7:0] char16, char4;
  logic       valid16, ferr16, busy16;
  logic       valid4, ferr4, busy4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] q16[$];
  logic [7:0] q4[$];
  int         vt16[$];
  int         ferr_pending16 = 0;
  int         nferr4 = 0;
  logic       prev_valid16 = 1'b0, prev_valid4 = 1'b0;

  uart_recv #(.OVERSAMPLE(16)) u_dut16 (
    .clk(clk), .rst(rst16), .pulse(pulse16), .signal(sig16),
    .character(char16), .valid(valid16), .frame_err(ferr16), .busy(busy16)
  );

  uart_recv #(.OVERSAMPLE(4)) u_dut4 (
    .clk(clk), .rst(rst4), .pulse(pulse4), .signal(sig4),
    .character(char4), .valid(valid4), .frame_err(ferr4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // pulse every 4 clk for the OVERSAMPLE=16 instance
  initial begin
    int pc = 0;
    forever begin
      @(negedge clk);
      pulse16 = (pc == 3);
      pc = (pc + 1) % 4;
    end
  end

  // Monitor / scoreboard for the OVERSAMPLE=16 instance
  always @(negedge clk) begin
    if (valid16) begin
      check("valid16 one clk wide", {31'd0, prev_valid16}, 32'd0);
      check("valid16 not with frame_err", {31'd0, ferr16}, 32'd0);
      if (q16.size() == 0) begin
        check("valid16 unexpected", 32'd1, 32'd0);
      end else begin
        check("char16", {24'd0, char16}, {24'd0, q16.pop_front()});
      end
      vt16.push_back(cyc);
    end
    if (ferr16) begin
      if (ferr_pending16 > 0) begin
        ferr_pending16--;
        check("frame_err16 expected", {31'd0, ferr16}, 32'd1);
      end else begin
        check("frame_err16 unexpected", 32'd1, 32'd0);
      end
    end
    prev_valid16 = valid16;
  end

  // Monitor / scoreboard for the OVERSAMPLE=4 instance
  always @(negedge clk) begin
    if (valid4) begin
      check("valid4 one clk wide", {31'd0, prev_valid4}, 32'd0);
      if (q4.size() == 0) begin
        check("valid4 unexpected", 32'd1, 32'd0);
      end else begin
        check("char4", {24'd0, char4}, {24'd0, q4.pop_front()});
      end
    end
    if (ferr4) begin
      nferr4++;
      check("frame_err4 unexpected", 32'd1, 32'd0);
    end
    prev_valid4 = valid4;
  end

  task automatic hold16(input logic v, input int clks);
    sig16 = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send16(input logic [7:0] b, input logic stop_v, input int idle);
    hold16(1'b0, 64);
    for (int i = 0; i < 8; i++) hold16(b[i], 64);
    hold16(stop_v, 64);
    hold16(1'b1, idle);
  endtask

  task automatic send4(input logic [7:0] b);
    sig4 = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sig4 = b[i];
      repeat (4) @(negedge clk);
    end
    sig4 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    rst16 = 1'b0;
    rst4  = 1'b0;
    @(negedge clk);
    check("reset char16", {24'd0, char16}, 32'h00);
    check("reset valid16", {31'd0, valid16}, 32'd0);
    check("reset ferr16", {31'd0, ferr16}, 32'd0);
    check("reset busy16", {31'd0, busy16}, 32'd0);
    check("reset char4", {24'd0, char4}, 32'h00);
    check("reset busy4", {31'd0, busy4}, 32'd0);
    repeat (20) @(negedge clk);

    fork
      begin : osr16
        logic [7:0] ab;
        // Good frame 0x64
        q16.push_back(8'h64);
        send16(8'h64, 1'b1, 64);
        check("busy16 after 0x64", {31'd0, busy16}, 32'd0);
        check("char16 hold 0x64", {24'd0, char16}, 32'h64);

        // Glitch: 3 ticks low then high
        hold16(1'b0, 12);
        check("busy16 during glitch", {31'd0, busy16}, 32'd1);
        hold16(1'b1, 60);
        check("busy16 after glitch", {31'd0, busy16}, 32'd0);
        check("char16 after glitch", {24'd0, char16}, 32'h64);

        // 0xA5 with bad stop bit, then 0x3C
        ferr_pending16++;
        send16(8'hA5, 1'b0, 128);
        check("frame_err16 seen", ferr_pending16, 32'd0);
        check("char16 after ferr", {24'd0, char16}, 32'h64);
        check("busy16 after ferr", {31'd0, busy16}, 32'd0);
        q16.push_back(8'h3C);
        send16(8'h3C, 1'b1, 64);
        check("char16 0x3C", {24'd0, char16}, 32'h3C);

        // Reset during data bit 4 of an abandoned frame
        ab = 8'h5A;
        hold16(1'b0, 64);
        for (int i = 0; i < 4; i++) hold16(ab[i], 64);
        hold16(ab[4], 32);
        rst16 = 1'b1;
        sig16 = 1'b1;
        repeat (2) @(negedge clk);
        rst16 = 1'b0;
        check("char16 after mid rst", {24'd0, char16}, 32'h00);
        check("busy16 after mid rst", {31'd0, busy16}, 32'd0);
        hold16(1'b1, 640);
        check("busy16 idle after rst", {31'd0, busy16}, 32'd0);
        q16.push_back(8'h81);
        send16(8'h81, 1'b1, 64);
        check("char16 0x81", {24'd0, char16}, 32'h81);

        // Back-to-back 0x00 then 0xFF
        q16.push_back(8'h00);
        q16.push_back(8'hFF);
        send16(8'h00, 1'b1, 0);
        send16(8'hFF, 1'b1, 64);
        check("char16 0xFF", {24'd0, char16}, 32'hFF);
        if (vt16.size() >= 2) begin
          int d;
          d = vt16[vt16.size()-1] - vt16[vt16.size()-2];
          check("b2b spacing in range", {31'd0, (d >= 636 && d <= 644)}, 32'd1);
        end else begin
          check("b2b valid count", vt16.size(), 32'd2);
        end
      end
      begin : osr4
        logic [7:0] b;
        for (int n = 0; n < 200; n++) begin
          if (n == 0) b = 8'h00;
          else if (n == 1) b = 8'hFF;
          else b = 8'($urandom);
          q4.push_back(b);
          send4(b);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("busy4 after stream", {31'd0, busy4}, 32'd0);
      end
    join

    repeat (20) @(negedge clk);
    check("q16 drained", q16.size(), 32'd0);
    check("q4 drained", q4.size(), 32'd0);
    check("frame_err4 count", nferr4, 32'd0);
    check("frame_err16 pending", ferr_pending16, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning the number of pulse ticks per bit period (even, >= 4).
REQ-002 SHALL have port clk  input  1  system clock; all logic rises on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port pulse  input  1  oversample tick, one clk wide, from the pulse generator; 8N1 timing counted only on cycles with pulse=1.
REQ-005 SHALL have port signal  input  1  asynchronous serial RX line, idle high.
REQ-006 SHALL have port character  output  8  last correctly received byte.
REQ-007 SHALL have port valid  output  1  one-clk strobe: character updated this cycle.
REQ-008 SHALL have port frame_err  output  1  one-clk strobe: stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass signal through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: on a pulse tick with rx_s=0 SHALL enter START and clear tick counter; no action on non-tick cycles.
REQ-013 START: SHALL count ticks; on the tick bringing the count to OVERSAMPLE/2, if rx_s=0 enter DATA with counter cleared and bit index 0, else return to IDLE (glitch reject, no strobe).
REQ-014 DATA: SHALL sample rx_s on every OVERSAMPLE-th tick (bit centre) into shift register bit index, LSB first; after index 7 is sampled, enter STOP.
REQ-015 STOP: on OVERSAMPLE-th tick, rx_s=1 SHALL load character with shift register, pulse valid, and go IDLE.
REQ-016 STOP: on OVERSAMPLE-th tick, rx_s=0 SHALL pulse frame_err, leave character unchanged, and enter WAIT_IDLE.
REQ-017 WAIT_IDLE: SHALL return to IDLE on the first tick with rx_s=1; no start detection before then.
REQ-018 valid and frame_err SHALL be registered, asserted the clk cycle after the deciding tick, high exactly one clk, never simultaneously.
REQ-019 Tick counter SHALL be sized ceil(log2(OVERSAMPLE)) bits and wrap to 0 after reaching OVERSAMPLE-1 in DATA/STOP; no overflow beyond that.
REQ-020 Back-to-back frames: a start bit immediately after a valid stop bit SHALL be detected on the next tick with rx_s=0 in IDLE, no dead time required.
REQ-021 Input latency: a line edge SHALL reach rx_s 2 clk later; start-to-valid latency SHALL be 9.5 bit periods + 1 tick-sample + 3 clk, within one tick of jitter.
REQ-022 pulse held high on consecutive cycles SHALL count as one tick per cycle (no edge detection on pulse).

Reset
REQ-023 While rst=1 on a clk edge: state=IDLE, counters=0, shift register=0, character=8'h00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abandon the frame with no strobe; the next frame after rst deasserts SHALL be received normally.
REQ-025 pulse and signal SHALL be ignored during reset.

Verification (OVERSAMPLE=16, pulse every 4 clk, bit = 64 clk)
REQ-026 Frame 0x64 (start 0, bits 0,0,1,0,0,1,1,0, stop 1) -> one valid strobe, character=8'h64, frame_err never high, busy low after.
REQ-027 Line low for 3 ticks then high -> state returns to IDLE from START, no valid/frame_err, busy high for ~8 ticks only.
REQ-028 Frame 0xA5 with stop bit driven 0, then line high -> frame_err one clk, character stays 8'h64, no valid; following 0x3C frame -> character=8'h3C.
REQ-029 rst pulsed for 2 clk during data bit 4 -> character=8'h00, busy=0, no strobes; subsequent 0x81 frame -> valid, character=8'h81.
REQ-030 Back-to-back 0x00 then 0xFF with single stop bits -> two valid strobes 640 clk apart (+/- one tick), characters 8'h00 then 8'hFF.
REQ-031 Random 200-byte stream with pulse period 1 (pulse tied high) and OVERSAMPLE=4 -> every byte matches scoreboard, zero frame_err.
